xgmac_axis_buffered_converter: RTL and testbench

Parametrised, FIFO-buffered bridge between the XGMAC client interface and AXI4-Stream, clocked on clk156. It sits between the 10G MAC and the port datapath in the 10G interface pcore. The RX side stores each frame and commits or discards it whole, so downstream `m_axis_tready` backpressure is honoured. The TX side starts the MAC only once a complete frame (or a configurable threshold) is buffered; frames up to the threshold therefore cannot underrun, and the block counts RX drops and TX underruns.

---
 rtl/xgmac_axis_buffered_converter.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_xgmac_axis_buffered_converter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xgmac_axis_buffered_converter.sv
// ---------------------------------------------------------------------------
// xgmac_axis_buffered_converter
//
// FIFO-buffered bridge between the 10G MAC client interface and AXI4-Stream,
// running entirely in the clk156 domain.
//
// RX path: MAC words are written speculatively into the RX FIFO.
//   - A frame becomes visible to the m_axis side only once its status word
//     commits it.
//   - Bad or overflowing frames are rewound in one cycle, so a frame is
//     either delivered whole or not at all.
//   - This lets m_axis_tready backpressure be honoured without corrupting
//     frames.
// TX path: s_axis words are buffered.
//   - The MAC is started only once a whole frame, or TX_THRESHOLD words,
//     is waiting in the buffer.
//   - A frame that drains the buffer mid-send is reported as an underrun and
//     the rest of that frame is flushed.
//
// Ports
//   clk156, reset           clock; synchronous active-high reset
//   rx_data/rx_data_valid   MAC receive word and byte enables
//   rx_good_frame           frame status, same cycle as the last word
//   rx_bad_frame            frame status, same cycle as the last word
//   m_axis_*                received frames out (tuser=1 marks a forwarded
//                           bad frame on its last beat)
//   s_axis_*                frames to transmit (s_axis_tuser unused)
//   tx_data/tx_data_valid   MAC transmit word and byte enables
//   tx_start, tx_ack        MAC transmit handshake
//   tx_underrun             one-cycle pulse when a frame runs dry
//   *_cnt                   saturating statistics counters
//
// Parameter rules
//   RX_DEPTH and TX_DEPTH must be powers of two, at least 16.
//   TX_THRESHOLD must be less than TX_DEPTH.
// ---------------------------------------------------------------------------
module xgmac_axis_buffered_converter #(
  parameter  int DATA_WIDTH   = 64,
  parameter  int RX_DEPTH     = 512,
  parameter  int TX_DEPTH     = 512,
  parameter  int TX_THRESHOLD = 256,
  parameter  int DROP_BAD     = 1,
  parameter  int CNT_WIDTH    = 32,
  localparam int KEEP_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk156,
  input  logic                  reset,
  // MAC receive
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic [KEEP_WIDTH-1:0] rx_data_valid,
  input  logic                  rx_good_frame,
  input  logic                  rx_bad_frame,
  // AXI4-Stream master (received frames)
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic [0:0]            m_axis_tuser,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  // AXI4-Stream slave (frames to transmit)
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [0:0]            s_axis_tuser,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  // MAC transmit
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic [KEEP_WIDTH-1:0] tx_data_valid,
  output logic                  tx_start,
  input  logic                  tx_ack,
  output logic                  tx_underrun,
  // Statistics
  output logic [CNT_WIDTH-1:0]  rx_frames_cnt,
  output logic [CNT_WIDTH-1:0]  rx_drop_cnt,
  output logic [CNT_WIDTH-1:0]  tx_frames_cnt,
  output logic [CNT_WIDTH-1:0]  tx_underrun_cnt
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);

  localparam logic [RX_AW:0]       RX_PTR_ONE = {{RX_AW{1'b0}}, 1'b1};
  localparam logic [TX_AW:0]       TX_PTR_ONE = {{TX_AW{1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TX_AW:0]       TX_THRESH  = TX_THRESHOLD[TX_AW:0];

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_ONE;
  endfunction

  // =========================================================================
  // RX path
  // =========================================================================
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic                  bad;
  } rx_entry_t;

  // RX_DISCARD doubles as the overflow flag.
  // The frame that overflowed is dropped when its status arrives.
  typedef enum logic [1:0] {
    RX_RESYNC,
    RX_IDLE,
    RX_RECV,
    RX_DISCARD
  } rx_state_t;

  rx_state_t  rx_state, rx_state_nxt;
  rx_entry_t  rx_mem [RX_DEPTH];
  rx_entry_t  rx_head;
  logic [RX_AW:0] rx_wr_spec, rx_wr_commit, rx_rd;

  logic rx_word, rx_status, rx_full, rx_commit_ok;
  logic rx_wr_en, rx_commit, rx_discard, rx_pop;

  assign rx_word      = |rx_data_valid;
  assign rx_status    = rx_good_frame | rx_bad_frame;
  assign rx_commit_ok = !rx_bad_frame || (DROP_BAD == 0);
  // Full is measured from the speculative write pointer, so an uncommitted
  // frame already occupies its space.
  assign rx_full      = (rx_wr_spec[RX_AW] != rx_rd[RX_AW]) &&
                        (rx_wr_spec[RX_AW-1:0] == rx_rd[RX_AW-1:0]);

  // NOTE: every signal written here gets a default first, so no path through the case leaves one unassigned and infers a latch.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_wr_en     = 1'b0;
    rx_commit    = 1'b0;
    rx_discard   = 1'b0;
    case (rx_state)
      // Wait for a gap so we never start mid-frame.
      RX_RESYNC: if (!rx_word) rx_state_nxt = RX_IDLE;
      RX_IDLE, RX_RECV: begin
        if (rx_word) begin
          if (rx_full) begin
            if (rx_status) begin
              rx_discard   = 1'b1;
              rx_state_nxt = RX_IDLE;
            end else begin
              rx_state_nxt = RX_DISCARD;
            end
          end else begin
            rx_wr_en = 1'b1;
            if (rx_status) begin
              rx_commit    = rx_commit_ok;
              rx_discard   = !rx_commit_ok;
              rx_state_nxt = RX_IDLE;
            end else begin
              rx_state_nxt = RX_RECV;
            end
          end
        end
      end
      RX_DISCARD: begin
        if (rx_word && rx_status) begin
          rx_discard   = 1'b1;
          rx_state_nxt = RX_IDLE;
        end
      end
      default: rx_state_nxt = RX_RESYNC;
    endcase
  end

  assign rx_pop = m_axis_tvalid && m_axis_tready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk156) begin
    if (reset) begin
      rx_state      <= RX_RESYNC;
      rx_wr_spec    <= '0;
      rx_wr_commit  <= '0;
      rx_rd         <= '0;
      rx_frames_cnt <= '0;
      rx_drop_cnt   <= '0;
    end else begin
      rx_state <= rx_state_nxt;
      if (rx_discard)    rx_wr_spec <= rx_wr_commit;
      else if (rx_wr_en) rx_wr_spec <= rx_wr_spec + RX_PTR_ONE;
      // The last word is written this cycle at rx_wr_spec.
      // Commit therefore points one past it.
      if (rx_commit) begin
        rx_wr_commit  <= rx_wr_spec + RX_PTR_ONE;
        rx_frames_cnt <= sat_inc(rx_frames_cnt);
      end
      if (rx_discard) rx_drop_cnt <= sat_inc(rx_drop_cnt);
      if (rx_pop)     rx_rd       <= rx_rd + RX_PTR_ONE;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk156) begin
    if (rx_wr_en)
      rx_mem[rx_wr_spec[RX_AW-1:0]] <= '{data: rx_data, keep: rx_data_valid,
                                         last: rx_status, bad: rx_bad_frame};
  end

  assign rx_head       = rx_mem[rx_rd[RX_AW-1:0]];
  assign m_axis_tvalid = (rx_rd != rx_wr_commit);
  assign m_axis_tdata  = rx_head.data;
  assign m_axis_tkeep  = rx_head.keep;
  assign m_axis_tlast  = rx_head.last;
  assign m_axis_tuser  = rx_head.bad;

  // =========================================================================
  // TX path
  // =========================================================================
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
  } tx_entry_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_WAIT_ACK,
    TX_SEND,
    TX_FLUSH
  } tx_state_t;

  tx_state_t  tx_state, tx_state_nxt;
  tx_entry_t  tx_mem [TX_DEPTH];
  tx_entry_t  tx_head;
  logic [TX_AW:0] tx_wr, tx_rd, tx_fill, tx_frames_avail;

  logic tx_full, tx_empty, tx_in_accept, tx_push, tx_pop;
  logic tx_drop_in, tx_sent_last;

  assign tx_fill       = tx_wr - tx_rd;
  assign tx_empty      = (tx_wr == tx_rd);
  assign tx_full       = (tx_wr[TX_AW] != tx_rd[TX_AW]) &&
                         (tx_wr[TX_AW-1:0] == tx_rd[TX_AW-1:0]);
  assign s_axis_tready = !tx_full;
  assign tx_in_accept  = s_axis_tvalid && s_axis_tready;
  // Words of a frame that already underran are accepted but not stored.
  assign tx_push       = tx_in_accept && !tx_drop_in;
  assign tx_head       = tx_mem[tx_rd[TX_AW-1:0]];
  assign tx_data       = tx_head.data;

  always_comb begin
    tx_state_nxt  = tx_state;
    tx_start      = 1'b0;
    tx_underrun   = 1'b0;
    tx_data_valid = '0;
    tx_pop        = 1'b0;
    tx_drop_in    = 1'b0;
    tx_sent_last  = 1'b0;
    case (tx_state)
      TX_IDLE:
        if (tx_frames_avail != '0 || tx_fill >= TX_THRESH) tx_state_nxt = TX_START;
      TX_START: begin
        tx_start     = 1'b1;
        tx_state_nxt = TX_WAIT_ACK;
      end
      TX_WAIT_ACK, TX_SEND: begin
        // The first word goes out combinationally in the ack cycle.
        // Every following SEND cycle carries one word.
        if (tx_state == TX_SEND || tx_ack) begin
          if (!tx_empty) begin
            tx_data_valid = tx_head.keep;
            tx_pop        = 1'b1;
            if (tx_head.last) begin
              tx_sent_last = 1'b1;
              tx_state_nxt = TX_IDLE;
            end else begin
              tx_state_nxt = TX_SEND;
            end
          end else if (tx_state == TX_SEND) begin
            tx_underrun  = 1'b1;
            tx_drop_in   = 1'b1;
            tx_state_nxt = (tx_in_accept && s_axis_tlast) ? TX_IDLE : TX_FLUSH;
          end else begin
            tx_state_nxt = TX_SEND;
          end
        end
      end
      TX_FLUSH: begin
        tx_drop_in = 1'b1;
        if (tx_in_accept && s_axis_tlast) tx_state_nxt = TX_IDLE;
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk156) begin
    if (reset) begin
      tx_state        <= TX_IDLE;
      tx_wr           <= '0;
      tx_rd           <= '0;
      tx_frames_avail <= '0;
      tx_frames_cnt   <= '0;
      tx_underrun_cnt <= '0;
    end else begin
      tx_state <= tx_state_nxt;
      if (tx_push) tx_wr <= tx_wr + TX_PTR_ONE;
      if (tx_pop)  tx_rd <= tx_rd + TX_PTR_ONE;
      // A frame arriving and one leaving in the same cycle cancel out.
      case ({tx_push && s_axis_tlast, tx_sent_last})
        2'b10:   tx_frames_avail <= tx_frames_avail + TX_PTR_ONE;
        2'b01:   tx_frames_avail <= tx_frames_avail - TX_PTR_ONE;
        default: tx_frames_avail <= tx_frames_avail;
      endcase
      if (tx_sent_last) tx_frames_cnt   <= sat_inc(tx_frames_cnt);
      if (tx_underrun)  tx_underrun_cnt <= sat_inc(tx_underrun_cnt);
    end
  end

  always_ff @(posedge clk156) begin
    if (tx_push)
      tx_mem[tx_wr[TX_AW-1:0]] <= '{data: s_axis_tdata, keep: s_axis_tkeep,
                                     last: s_axis_tlast};
  end

endmodule

// File: tb/tb_xgmac_axis_buffered_converter.sv
`timescale 1ns/1ps
module tb_xgmac_axis_buffered_converter;

  // Two instances share all inputs: g_dut[0] drops bad frames, g_dut[1] forwards them.
  logic        clk156 = 1'b0;
  logic        reset;
  logic [63:0] rx_data;
  logic [7:0]  rx_data_valid;
  logic        rx_good_frame, rx_bad_frame;
  logic        m_axis_tready;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic [0:0]  s_axis_tuser;
  logic        s_axis_tvalid, s_axis_tlast;
  logic        tx_ack;

  logic [63:0] m_tdata [2];
  logic [7:0]  m_tkeep [2];
  logic [0:0]  m_tuser [2];
  logic        m_tvalid [2];
  logic        m_tlast [2];
  logic        s_tready [2];
  logic [63:0] tx_d [2];
  logic [7:0]  tx_dv [2];
  logic        tx_st [2];
  logic        tx_ur [2];
  logic [31:0] rx_frames [2];
  logic [31:0] rx_drops [2];
  logic [31:0] tx_frames [2];
  logic [31:0] tx_urs [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    xgmac_axis_buffered_converter #(
      .DATA_WIDTH(64), .RX_DEPTH(16), .TX_DEPTH(16), .TX_THRESHOLD(4),
      .DROP_BAD(g == 0 ? 1 : 0), .CNT_WIDTH(32)
    ) u_dut (
      .clk156(clk156), .reset(reset),
      .rx_data(rx_data), .rx_data_valid(rx_data_valid),
      .rx_good_frame(rx_good_frame), .rx_bad_frame(rx_bad_frame),
      .m_axis_tdata(m_tdata[g]), .m_axis_tkeep(m_tkeep[g]), .m_axis_tuser(m_tuser[g]),
      .m_axis_tvalid(m_tvalid[g]), .m_axis_tlast(m_tlast[g]), .m_axis_tready(m_axis_tready),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_tready[g]),
      .tx_data(tx_d[g]), .tx_data_valid(tx_dv[g]), .tx_start(tx_st[g]), .tx_ack(tx_ack),
      .tx_underrun(tx_ur[g]),
      .rx_frames_cnt(rx_frames[g]), .rx_drop_cnt(rx_drops[g]),
      .tx_frames_cnt(tx_frames[g]), .tx_underrun_cnt(tx_urs[g])
    );
  end

  always #5 clk156 = ~clk156;

  int cyc = 0;
  always @(posedge clk156) cyc <= cyc + 1;

  typedef struct packed { logic [63:0] d; logic [7:0] k; logic l; logic u; } beat_t;
  typedef struct packed { logic [63:0] d; logic [7:0] k; logic [31:0] c; } txw_t;

  beat_t rxq0[$];
  beat_t rxq1[$];
  txw_t  txq[$];
  int    start_cnt, start_cyc, underrun_cnt;
  int    checks = 0;
  int    errors = 0;

  // Observe outputs on the falling edge, half a cycle away from the active edge.
  always @(negedge clk156) begin
    if (m_tvalid[0] && m_axis_tready) rxq0.push_back({m_tdata[0], m_tkeep[0], m_tlast[0], m_tuser[0]});
    if (m_tvalid[1] && m_axis_tready) rxq1.push_back({m_tdata[1], m_tkeep[1], m_tlast[1], m_tuser[1]});
    if (tx_dv[0] != 8'h00) txq.push_back({tx_d[0], tx_dv[0], cyc});
    if (tx_st[0]) begin start_cnt++; start_cyc = cyc; end
    if (tx_ur[0]) underrun_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk156); #1; end
  endtask

  task automatic rx_frame(input int n, input logic [7:0] last_keep, input logic bad,
                          input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      rx_data       = base + 64'(i);
      rx_data_valid = (i == n - 1) ? last_keep : 8'hFF;
      rx_good_frame = (i == n - 1) && !bad;
      rx_bad_frame  = (i == n - 1) && bad;
      tick(1);
    end
    rx_data_valid = 8'h00;
    rx_good_frame = 1'b0;
    rx_bad_frame  = 1'b0;
  endtask

  task automatic tx_frame(input int n, input logic [63:0] base, input logic [7:0] last_keep,
                          input int stall_at, input int stall_len);
    for (int i = 0; i < n; i++) begin
      if (stall_at > 0 && i == stall_at) begin
        s_axis_tvalid = 1'b0;
        tick(stall_len);
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = base + 64'(i);
      s_axis_tkeep  = (i == n - 1) ? last_keep : 8'hFF;
      s_axis_tlast  = (i == n - 1);
      for (int w = 0; w < 50 && !s_tready[0]; w++) tick(1);
      tick(1);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic ack_after_start(input int delay);
    logic found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (tx_st[0]) found = 1'b1;
      else tick(1);
    end
    check("tx_start_seen", 64'(found), 64'd1);
    if (found) begin
      tick(delay);
      tx_ack = 1'b1;
      tick(1);
      tx_ack = 1'b0;
    end
  endtask

  initial begin
    beat_t b;
    txw_t  t;
    reset = 1'b1;
    rx_data = '0; rx_data_valid = '0; rx_good_frame = 1'b0; rx_bad_frame = 1'b0;
    m_axis_tready = 1'b0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    tx_ack = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);

    // Reset state
    check("rst_m_tvalid", 64'(m_tvalid[0]), 64'd0);
    check("rst_tx_start", 64'(tx_st[0]), 64'd0);
    check("rst_tx_underrun", 64'(tx_ur[0]), 64'd0);
    check("rst_tx_data_valid", 64'(tx_dv[0]), 64'd0);
    check("rst_s_tready", 64'(s_tready[0]), 64'd1);
    check("rst_counters", {rx_frames[0] | rx_drops[0], tx_frames[0] | tx_urs[0]}, 64'd0);

    // RX single 8-word frame, last keep 0x0F
    m_axis_tready = 1'b1;
    rxq0.delete(); rxq1.delete();
    rx_frame(8, 8'h0F, 1'b0, 64'h100);
    check("rx1_commit_latency", 64'(m_tvalid[0]), 64'd1);
    tick(10);
    check("rx1_beats", 64'(rxq0.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      b = (i < rxq0.size()) ? rxq0[i] : '0;
      check($sformatf("rx1_data%0d", i), b.d, 64'h100 + 64'(i));
      check($sformatf("rx1_last%0d", i), 64'(b.l), 64'(i == 7));
    end
    b = (rxq0.size() == 8) ? rxq0[7] : '0;
    check("rx1_last_keep", 64'(b.k), 64'h0F);
    check("rx1_last_user", 64'(b.u), 64'd0);
    check("rx1_frames_cnt", 64'(rx_frames[0]), 64'd1);

    // RX backpressure: two 4-word frames while tready is low for 20 cycles
    m_axis_tready = 1'b0;
    rxq0.delete(); rxq1.delete();
    rx_frame(4, 8'hFF, 1'b0, 64'h200);
    rx_frame(4, 8'hFF, 1'b0, 64'h300);
    tick(20);
    check("rx2_no_beats_stalled", 64'(rxq0.size()), 64'd0);
    check("rx2_tvalid_held", 64'(m_tvalid[0]), 64'd1);
    check("rx2_tdata_held", m_tdata[0], 64'h200);
    m_axis_tready = 1'b1;
    tick(12);
    check("rx2_beats", 64'(rxq0.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      b = (i < rxq0.size()) ? rxq0[i] : '0;
      check($sformatf("rx2_data%0d", i), b.d, (i < 4) ? 64'h200 + 64'(i) : 64'h300 + 64'(i - 4));
      check($sformatf("rx2_last%0d", i), 64'(b.l), 64'(i == 3 || i == 7));
    end
    check("rx2_frames_cnt", 64'(rx_frames[0]), 64'd3);

    // RX overflow: 20-word frame into a 16-deep FIFO with tready low
    m_axis_tready = 1'b0;
    rxq0.delete(); rxq1.delete();
    rx_frame(20, 8'hFF, 1'b0, 64'h400);
    tick(2);
    check("rx3_drop_cnt", 64'(rx_drops[0]), 64'd1);
    check("rx3_tvalid", 64'(m_tvalid[0]), 64'd0);
    check("rx3_frames_cnt", 64'(rx_frames[0]), 64'd3);
    m_axis_tready = 1'b1;
    rx_frame(4, 8'hFF, 1'b0, 64'h500);
    tick(8);
    check("rx3_beats", 64'(rxq0.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      b = (i < rxq0.size()) ? rxq0[i] : '0;
      check($sformatf("rx3_data%0d", i), b.d, 64'h500 + 64'(i));
      check($sformatf("rx3_last%0d", i), 64'(b.l), 64'(i == 3));
    end
    check("rx3_frames_cnt_after", 64'(rx_frames[0]), 64'd4);

    // RX bad frame: dropped by instance 0, forwarded with tuser by instance 1
    rxq0.delete(); rxq1.delete();
    rx_frame(3, 8'h03, 1'b1, 64'h600);
    tick(6);
    check("rx4_drop_beats", 64'(rxq0.size()), 64'd0);
    check("rx4_drop_cnt", 64'(rx_drops[0]), 64'd2);
    check("rx4_fwd_beats", 64'(rxq1.size()), 64'd3);
    b = (rxq1.size() == 3) ? rxq1[0] : '1;
    check("rx4_fwd_user_first", 64'(b.u), 64'd0);
    b = (rxq1.size() == 3) ? rxq1[2] : '0;
    check("rx4_fwd_user_last", 64'(b.u), 64'd1);
    check("rx4_fwd_keep_last", 64'(b.k), 64'h03);
    check("rx4_fwd_data_last", b.d, 64'h602);
    check("rx4_fwd_frames_cnt", 64'(rx_frames[1]), 64'd5);
    check("rx4_fwd_drop_cnt", 64'(rx_drops[1]), 64'd1);

    // TX normal: 6-word frame, ack 3 cycles after tx_start
    txq.delete(); start_cnt = 0; underrun_cnt = 0;
    fork
      tx_frame(6, 64'hA00, 8'h3F, 0, 0);
      ack_after_start(3);
    join
    tick(5);
    check("tx1_start_pulses", 64'(start_cnt), 64'd1);
    check("tx1_words", 64'(txq.size()), 64'd6);
    t = (txq.size() > 0) ? txq[0] : '0;
    check("tx1_first_word_cycle", 64'(t.c) - 64'(start_cyc), 64'd3);
    for (int i = 0; i < 6; i++) begin
      txw_t u;
      u = (i < txq.size()) ? txq[i] : '0;
      check($sformatf("tx1_data%0d", i), u.d, 64'hA00 + 64'(i));
      check($sformatf("tx1_cycle%0d", i), 64'(u.c), 64'(t.c) + 64'(i));
    end
    t = (txq.size() == 6) ? txq[5] : '0;
    check("tx1_last_keep", 64'(t.k), 64'h3F);
    check("tx1_no_underrun", 64'(underrun_cnt), 64'd0);
    check("tx1_frames_cnt", 64'(tx_frames[0]), 64'd1);
    check("tx1_underrun_cnt", 64'(tx_urs[0]), 64'd0);

    // TX underrun: 10-word frame, source stalls after word 5
    txq.delete(); start_cnt = 0; underrun_cnt = 0;
    fork
      tx_frame(10, 64'hB00, 8'hFF, 5, 15);
      ack_after_start(1);
    join
    tick(10);
    check("tx2_underrun_pulses", 64'(underrun_cnt), 64'd1);
    check("tx2_underrun_cnt", 64'(tx_urs[0]), 64'd1);
    check("tx2_start_pulses", 64'(start_cnt), 64'd1);
    check("tx2_words", 64'(txq.size()), 64'd5);
    t = (txq.size() == 5) ? txq[4] : '0;
    check("tx2_last_sent_data", t.d, 64'hB04);
    check("tx2_frames_cnt", 64'(tx_frames[0]), 64'd1);

    // TX clean frame after the flush
    txq.delete(); start_cnt = 0; underrun_cnt = 0;
    fork
      tx_frame(6, 64'hC00, 8'hFF, 0, 0);
      ack_after_start(2);
    join
    tick(6);
    check("tx3_start_pulses", 64'(start_cnt), 64'd1);
    check("tx3_words", 64'(txq.size()), 64'd6);
    t = (txq.size() > 0) ? txq[0] : '0;
    for (int i = 0; i < 6; i++) begin
      txw_t u;
      u = (i < txq.size()) ? txq[i] : '0;
      check($sformatf("tx3_data%0d", i), u.d, 64'hC00 + 64'(i));
      check($sformatf("tx3_cycle%0d", i), 64'(u.c), 64'(t.c) + 64'(i));
    end
    check("tx3_no_underrun", 64'(underrun_cnt), 64'd0);
    check("tx3_frames_cnt", 64'(tx_frames[0]), 64'd2);
    check("tx3_underrun_cnt", 64'(tx_urs[0]), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
